// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer.
package cpu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned TMO_W           = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: drives a req/ack data memory, stalls the pipeline
// while an access is outstanding and returns load data to MEM/WB.
module dmem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [XLEN-1:0]  ALUdata_i,
  input  logic [XLEN-1:0]  MemWdata_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic [XLEN-1:0]  rdata_o,
  output logic             rdata_valid_o,
  output logic             stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              access;

  assign access  = MemRead_i | MemWrite_i;
  assign stall_o = ((state_q == IDLE) && access) || (state_q == REQ);

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (access) begin
          addr_d  = ALUdata_i;
          wdata_d = MemWdata_i;
          we_d    = MemWrite_i;
          req_d   = 1'b1;
          state_d = REQ;
          if (MemRead_i && MemWrite_i) err_d = 1'b1;
        end
      end
      REQ: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Ack is tested first so an ack on the final allowed cycle beats the timeout.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d  = mem_rdata_i;
            rvalid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d  = '0;
            rvalid_d = 1'b1;
          end
        end
      end
      DONE: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .inc_i   (stall_o),
    .cnt_o   (stall_cnt_o)
  );

  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign err_o         = err_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the MEM stage of the 5-stage pipeline against a variable-latency data memory using a req/ack handshake.
- Takes the registered EX/MEM control and data outputs (MemRead, MemWrite, ALU result as address, store data) and drives the memory port.
- Raises stall_o to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Presents load data to MEM/WB and keeps a saturating stall-cycle performance counter.

Parameters:
TIMEOUT, 255, REQ-state cycles without mem_ack_i before abort (1..65535)
CNT_W, 16, width of stall-cycle counter

Ports:
clk_i  in  1  clock
start_i  in  1  reset; asynchronous, active-low
MemRead_i  in  1  load in MEM stage (from EX/MEM)
MemWrite_i  in  1  store in MEM stage (from EX/MEM)
ALUdata_i  in  32  byte address (from EX/MEM)
MemWdata_i  in  32  store data (from EX/MEM)
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  1=write, 0=read; valid with mem_req_o
mem_addr_o  out  32  latched address
mem_wdata_o  out  32  latched store data
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  32  read data; valid when mem_ack_i=1
rdata_o  out  32  load data to MEM/WB
rdata_valid_o  out  1  rdata_o updated this cycle (one cycle pulse)
stall_o  out  1  freeze upstream pipeline registers
err_o  out  1  sticky: timeout or MemRead_i&MemWrite_i seen
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o=1

Behaviour:
- Reset (start_i=0, any time incl. mid-access): state IDLE; mem_req_o, mem_we_o, rdata_valid_o, err_o = 0; mem_addr_o, mem_wdata_o, rdata_o = 0; stall_cnt_o = 0; timeout counter = 0. Outstanding request is dropped; a late ack after reset is ignored.
- access = MemRead_i | MemWrite_i.
- stall_o is combinational: 1 when (state==IDLE & access) or state==REQ; otherwise 0.
- IDLE:
  - If access: latch ALUdata_i to mem_addr_o and MemWdata_i to mem_wdata_o.
  - mem_we_o = MemWrite_i (write wins if both are set; err_o is then set).
  - Next state REQ, with mem_req_o=1.
  - If no access: remain in IDLE.
- REQ:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - Timeout counter increments each cycle.
  - On mem_ack_i: mem_req_o→0; next DONE. For a read, rdata_o←mem_rdata_i and rdata_valid_o=1 during DONE.
  - Counter reaches TIMEOUT with no ack: mem_req_o→0, err_o→1, rdata_o←0, next DONE. rdata_valid_o=1 if the access was a read.
  - ack in the same cycle as timeout: ack wins; no error.
- DONE:
  - stall_o=0 for exactly one cycle, so the pipeline advances at the closing edge. The access is still visible on the inputs during DONE and must not retrigger.
  - rdata_valid_o deasserts; next IDLE.
  - Timeout counter clears.
- Latency: an ack in the first REQ cycle gives IDLE→REQ→DONE = 3 cycles per memory instruction, 2 of them stalled. Back-to-back accesses repeat this with no gap beyond DONE.
- mem_ack_i in IDLE or DONE is ignored.
- rdata_o holds its value until the next read completes; writes never alter it.
- stall_cnt_o increments every cycle with stall_o=1 and saturates at all-ones.
- err_o clears only on reset.

Decomposition:
- Shared package (cpu_pkg): state encoding localparams (IDLE=2'd0, REQ=2'd1, DONE=2'd2), XLEN=32, default TIMEOUT.
- One sub-module, sat_counter (parameter W; ports: clk_i, start_i, inc_i, cnt_o), instantiated for stall_cnt_o.
- FSM, latches and timeout counter stay in the top module.

Test Plan:
- Load, ack in 1st REQ cycle: MemRead_i=1, ALUdata_i=0x100, mem_rdata_i=0xDEADBEEF → stall_o=1 for 2 cycles; mem_req_o=1 for 1 cycle with mem_we_o=0, mem_addr_o=0x100; rdata_o=0xDEADBEEF and rdata_valid_o=1 in DONE; stall_cnt_o=2.
- Store, ack after 5 cycles: MemWrite_i=1, ALUdata_i=0x20, MemWdata_i=0x12345678 → mem_we_o=1 and address/data stable for 5 REQ cycles; stall_o=1 for 6 cycles; rdata_o unchanged.
- Timeout with TIMEOUT=4 and no ack → mem_req_o drops after 4 cycles; err_o=1 (sticky); rdata_o=0, rdata_valid_o=1 for the read; pipeline released.
- Back-to-back load then store, each acked immediately → each sees exactly one DONE cycle with stall_o=0; no duplicate request; stall_cnt_o=4.
- start_i low during REQ, then a stray mem_ack_i after release → all outputs 0; state IDLE; stray ack ignored; no rdata_valid_o.
- MemRead_i=MemWrite_i=1 → treated as write (mem_we_o=1); err_o=1.
